// File: rtl/arb_requester_if.sv
// Request/grant bus between arb_requester and the fixed-priority arbiter,
// plus the local-client job, status and error signals.
interface arb_requester_if;
  logic [3:0] job_push;
  logic [3:0] GNT;
  logic [3:0] REQ;
  logic [3:0] beat;
  logic [3:0] done;
  logic [3:0] ovf;
  logic [3:0] pend_full;
  logic       err;

  modport master (
    input  job_push, GNT,
    output REQ, beat, done, ovf, pend_full, err
  );

  modport slave (
    output job_push, GNT,
    input  REQ, beat, done, ovf, pend_full, err
  );
endinterface

// File: rtl/arb_requester.sv
// Requester side of the 4-channel arbiter: per-channel job queue, REQ drive and
// beat/burst counting. Define ARB_REQ_GNT_CHECK_EN to build the grant-protocol checker.
module arb_requester #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic            clk,
  input  logic            reset,
  arb_requester_if.master bus
);

  localparam logic [3:0]       LAST     = 4'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, WAIT, XFER} ch_state_e;

  ch_state_e        state_q [4];
  ch_state_e        state_d [4];
  logic [3:0]       bcnt_q  [4];
  logic [3:0]       bcnt_d  [4];
  logic [CNT_W-1:0] pend_q  [4];
  logic [CNT_W-1:0] pend_d  [4];

  logic [3:0] req, granted, final_beat, accept, drop, full_d;
  logic [3:0] beat_q, done_q, ovf_q, full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        bcnt_q[i]  <= '0;
        pend_q[i]  <= '0;
      end
      beat_q <= '0;
      done_q <= '0;
      ovf_q  <= '0;
      full_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        bcnt_q[i]  <= bcnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
      beat_q <= granted;
      done_q <= final_beat;
      ovf_q  <= drop;
      full_q <= full_d;
    end
  end

  always_comb begin
    req        = '0;
    granted    = '0;
    final_beat = '0;
    accept     = '0;
    drop       = '0;
    full_d     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      bcnt_d[i]  = bcnt_q[i];
      pend_d[i]  = pend_q[i];

      // A grant while REQ is low is the arbiter lagging our REQ by one cycle.
      req[i]        = (state_q[i] != IDLE);
      granted[i]    = req[i] & bus.GNT[i];
      final_beat[i] = granted[i] && (bcnt_q[i] == LAST);
      // A final beat frees a slot in the same cycle, so a push at full still fits.
      accept[i]     = bus.job_push[i] && ((pend_q[i] != PEND_MAX) || final_beat[i]);
      drop[i]       = bus.job_push[i] && !accept[i];

      if (accept[i] && !final_beat[i])
        pend_d[i] = pend_q[i] + CNT_W'(1);
      else if (!accept[i] && final_beat[i])
        pend_d[i] = pend_q[i] - CNT_W'(1);

      if (final_beat[i])
        bcnt_d[i] = '0;
      else if (granted[i])
        bcnt_d[i] = bcnt_q[i] + 4'd1;

      full_d[i] = (pend_d[i] == PEND_MAX);

      if (pend_d[i] == '0)
        state_d[i] = IDLE;
      else if (bcnt_d[i] != '0)
        state_d[i] = XFER;
      else
        state_d[i] = WAIT;
    end
  end

  assign bus.REQ       = req;
  assign bus.beat      = beat_q;
  assign bus.done      = done_q;
  assign bus.ovf       = ovf_q;
  assign bus.pend_full = full_q;

`ifdef ARB_REQ_GNT_CHECK_EN
  logic [3:0] req_prev;
  logic       err_q;
  logic       multi_hot, spurious;

  assign multi_hot = ((bus.GNT & (bus.GNT - 4'd1)) != '0);
  // Only a grant with REQ low for two consecutive cycles cannot be explained by arbiter lag.
  assign spurious  = ((bus.GNT & ~req & ~req_prev) != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      req_prev <= '0;
      err_q    <= 1'b0;
    end else begin
      req_prev <= req;
      if (multi_hot || spurious)
        err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
